// File: rtl/iota_rc_stream_pkg.sv
// Shared definitions for the iota-step round-constant stream: lane sizing,
// the round-constant LFSR helpers and the controller state type.
package iota_rc_stream_pkg;

    localparam int LANE_SIZE        = 64;
    localparam int L_SIZE           = 6;
    localparam int ROUND_INDEX_SIZE = 5;

    localparam logic [7:0] RC_LFSR_INIT = 8'h01;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } iota_state_e;

    // rc bits for one round (bit j = rc(7*ir + j)) and the LFSR state that follows
    typedef struct packed {
        logic [L_SIZE:0] rc;
        logic [7:0]      next;
    } rc_round_t;

    // One step of x^8+x^6+x^5+x^4+1; bit 0 of the state is the current rc bit.
    function automatic logic [7:0] lfsr_step8(input logic [7:0] s);
        return {s[6:0], 1'b0} ^ (s[7] ? 8'h71 : 8'h00);
    endfunction

    // LFSR state after t steps from the initial value; used to skip ahead to
    // the first round of a reduced-round variant at elaboration time.
    function automatic logic [7:0] rc_seed(input int t);
        logic [7:0] s;
        s = RC_LFSR_INIT;
        for (int i = 0; i < t; i++) begin
            s = lfsr_step8(s);
        end
        return s;
    endfunction

    // Seven unrolled steps: the full set of rc bits for one round.
    function automatic rc_round_t rc_round(input logic [7:0] s);
        rc_round_t  r;
        logic [7:0] cur;
        cur  = s;
        r.rc = '0;
        for (int j = 0; j <= L_SIZE; j++) begin
            r.rc[j] = cur[0];
            cur     = lfsr_step8(cur);
        end
        r.next = cur;
        return r;
    endfunction

    function automatic int lane_log2(input int w);
        return $clog2(w);
    endfunction

    function automatic int full_rounds(input int w);
        return 12 + 2 * $clog2(w);
    endfunction

endpackage

// File: rtl/iota_rc_stream_rc_lfsr.sv
// Round-constant generator: 8-bit LFSR register that yields the rc bits of
// the current round and moves on to the next round when advanced.
module keccak_rc_lfsr
    import iota_rc_stream_pkg::*;
#(
    parameter logic [7:0] SEED = RC_LFSR_INIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              adv_i,
    output logic [L_SIZE:0]   rc_o
);

    logic [7:0] lfsr_q;
    rc_round_t  rnd;

    // Unroll the seven steps of the current round combinationally.
    always_comb begin
        rnd = rc_round(lfsr_q);
    end

    assign rc_o = rnd.rc;

    // Reload to the first-round seed on start, otherwise jump a whole round per accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else if (load_i) begin
            lfsr_q <= SEED;
        end else if (adv_i) begin
            lfsr_q <= rnd.next;
        end
    end

endmodule

// File: rtl/iota_rc_stream.sv
// Iota step for an iterative Keccak-f core: XORs the on-the-fly round
// constant into lane(0,0) once per round behind a registered valid/ready stage.
//
// state | meaning
// IDLE  | waiting for start_i, input blocked
// RUN   | accepting one lane per round
// FLUSH | all rounds accepted, draining the final lane
module iota_rc_stream
    import iota_rc_stream_pkg::*;
#(
    parameter int LANE_W     = LANE_SIZE,
    parameter int NUM_ROUNDS = full_rounds(LANE_W)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start_i,
    input  logic                        abort_i,
    input  logic                        lane_valid_i,
    output logic                        lane_ready_o,
    input  logic [LANE_W-1:0]           lane00_i,
    output logic                        lane_valid_o,
    input  logic                        lane_ready_i,
    output logic [LANE_W-1:0]           lane00_o,
    output logic [ROUND_INDEX_SIZE-1:0] round_idx_o,
    output logic                        last_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int L           = lane_log2(LANE_W);
    localparam int FIRST_ROUND = full_rounds(LANE_W) - NUM_ROUNDS;
    localparam logic [7:0] SEED = rc_seed(7 * FIRST_ROUND);
    localparam logic [ROUND_INDEX_SIZE-1:0] FIRST_IDX = ROUND_INDEX_SIZE'(FIRST_ROUND);
    localparam logic [ROUND_INDEX_SIZE-1:0] LAST_CNT  = ROUND_INDEX_SIZE'(NUM_ROUNDS - 1);

    iota_state_e                 state_q, state_d;
    logic [ROUND_INDEX_SIZE-1:0] cnt_q;
    logic                        vld_q;
    logic [LANE_W-1:0]           data_q;
    logic [ROUND_INDEX_SIZE-1:0] idx_q;
    logic                        last_q;
    logic                        accept;
    logic                        lfsr_load;
    logic [L_SIZE:0]             rc7;
    logic [LANE_W-1:0]           rc_lane;

    keccak_rc_lfsr #(
        .SEED (SEED)
    ) u_rc_lfsr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (lfsr_load),
        .adv_i  (accept),
        .rc_o   (rc7)
    );

    // Place rc bit j at lane bit 2^j-1; only bits up to L fit the lane.
    always_comb begin
        rc_lane = '0;
        for (int j = 0; j <= L; j++) begin
            rc_lane[(1 << j) - 1] = rc7[j];
        end
    end

    // Next state, input ready and done pulse; abort overrides everything.
    always_comb begin
        state_d      = state_q;
        lane_ready_o = 1'b0;
        done_o       = 1'b0;
        accept       = 1'b0;
        lfsr_load    = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d   = RUN;
                        lfsr_load = 1'b1;
                    end
                end
                RUN: begin
                    lane_ready_o = !vld_q || lane_ready_i;
                    accept       = lane_valid_i && lane_ready_o;
                    if (accept && (cnt_q == LAST_CNT)) begin
                        state_d = FLUSH;
                    end
                end
                FLUSH: begin
                    if (vld_q && lane_ready_i) begin
                        done_o  = 1'b1;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Round counter: cleared on start/abort, bumped per accepted lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (abort_i || lfsr_load) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Output stage: load on accept (also replaces a lane leaving the same
    // cycle), drop valid on a plain handshake, hold everything while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
        end else if (abort_i) begin
            vld_q  <= 1'b0;
            last_q <= 1'b0;
        end else if (accept) begin
            vld_q  <= 1'b1;
            data_q <= lane00_i ^ rc_lane;
            idx_q  <= FIRST_IDX + cnt_q;
            last_q <= (cnt_q == LAST_CNT);
        end else if (vld_q && lane_ready_i) begin
            vld_q <= 1'b0;
        end
    end

    assign lane_valid_o = vld_q;
    assign lane00_o     = data_q;
    assign round_idx_o  = idx_q;
    assign last_o       = last_q;
    assign busy_o       = (state_q != IDLE);

endmodule

// File: doc/iota_rc_stream.md
Name: iota_rc_stream

Overview:
- Sequential, parametrised ι-step engine for Keccak-f[b] with b = 25·LANE_W.
- Generates round constants on the fly with the FIPS202 Algorithm 5 LFSR (x^8+x^6+x^5+x^4+1) instead of a stored table.
- XORs each constant into a stream of lane(0,0) words, one per round, through a valid/ready registered output stage.
- Sits between the θρπχ datapath and the state register in the iterative permutation core.
- Supports reduced-round variants (e.g. 12-round TurboSHAKE) and narrow lanes.

Parameters:
- LANE_W, 64, lane width w ∈ {8,16,32,64}; L = log2(LANE_W) derived.
- NUM_ROUNDS, 12+2L, rounds per permutation (1..12+2L).
- FIRST_ROUND, 12+2L-NUM_ROUNDS, FIPS round index ir of the first round (derived, not overridable).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  begin a permutation; honoured only in IDLE
- abort_i  in  1  synchronous clear to IDLE; highest priority after reset
- lane_valid_i  in  1  input lane valid
- lane_ready_o  out  1  input lane accepted when valid&ready
- lane00_i  in  LANE_W  lane(0,0) after χ
- lane_valid_o  out  1  output lane valid
- lane_ready_i  in  1  downstream ready
- lane00_o  out  LANE_W  lane(0,0) after ι
- round_idx_o  out  ROUND_INDEX_SIZE  ir of the lane currently held at the output
- last_o  out  1  output lane is the final round
- busy_o  out  1  state != IDLE
- done_o  out  1  one-cycle pulse when the final lane handshakes out

Behaviour:
- Reset values: all outputs 0; state IDLE; LFSR = SEED; round counter = 0.
- SEED = LFSR state after 7·FIRST_ROUND steps from 0x01, computed at elaboration by a package constant function.
- RC(ir) bit (2^j−1) = rc(j+7·ir) for j = 0..L. All other bits are 0. Lane width truncates to the low LANE_W bits.
- One round constant per cycle: 7 LFSR steps unrolled combinationally from the current LFSR register; the register advances only on an accepted input.
- FSM:
  - IDLE: lane_ready_o = 0. start_i → RUN; LFSR reloaded to SEED; counter = 0.
  - RUN: lane_ready_o = !lane_valid_o || lane_ready_i. On accept: output register ← lane00_i ^ RC; round_idx_o ← FIRST_ROUND+cnt; last_o ← (cnt == NUM_ROUNDS−1); cnt++; LFSR advances. Accepting the last round → FLUSH.
  - FLUSH: lane_ready_o = 0. When lane_valid_o & lane_ready_i: done_o = 1 that cycle; → IDLE.
- Output stage:
  - lane_valid_o set on accept.
  - Cleared on output handshake without a simultaneous accept.
  - Simultaneous handshake-out and accept: back-to-back replace, giving full throughput of 1 lane/cycle.
- Latency: input accept → lane00_o valid next cycle.
- Output data, round_idx_o and last_o are held stable while lane_valid_o & !lane_ready_i.
- start_i in RUN/FLUSH is ignored. lane_valid_i in IDLE/FLUSH is ignored (not consumed).
- abort_i → IDLE next cycle; lane_valid_o cleared; no done_o; takes precedence over start_i and accept in the same cycle.
- Asynchronous reset mid-operation: immediate return to reset values.
- Counter width is ROUND_INDEX_SIZE; no wrap is possible because FLUSH blocks input after NUM_ROUNDS accepts.

Decomposition:
- keccak_pkg additions:
  - lfsr_step8() function
  - rc_seed(int t) constant function
  - rc_round(lfsr_state) returning 7 rc bits plus next state
  - function log2 lane helpers
  - iota_state_e enum {IDLE,RUN,FLUSH}
- Existing LANE_SIZE, ROUND_INDEX_SIZE and L_SIZE are reused.
- One sub-module: keccak_rc_lfsr. It holds the 8-bit register, load/advance controls, and the 7-bit rc output.

Test Plan:
- Default params, zero lanes, lane_ready_i=1, start then 24 consecutive lanes → lane00_o for round 0 = 0x0000000000000001, round 1 = 0x0000000000008082, round 23 = 0x8000000080008008; last_o and done_o only on round 23; done_o 1 cycle after the round-23 accept.
- NUM_ROUNDS=12 → first output round_idx_o=12, lane00_o=0x000000008000808B; final output 0x8000000080008008.
- LANE_W=8 (18 rounds), lane00_i=0xFF → round 0 output 0xFE, round 1 output 0x7D.
- Backpressure: lane_ready_i low for 5 cycles mid-run → lane_ready_o=0, lane00_o/round_idx_o stable, no skipped or duplicated constants versus the golden model.
- abort_i at round 10 → IDLE next cycle, lane_valid_o=0, no done_o. A new start then replays round 0 = 0x…01.
- Reset asserted during FLUSH → all outputs 0 immediately; start_i in FLUSH before reset and lane_valid_i in IDLE are ignored.
